// File: rtl/enable_ctrl_pkg.sv
// Shared types and constants for the enable burst controller.
package enable_ctrl_pkg;

  // Sequencer states; the encoding is exposed on the controller's fsm_state port.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_PERIOD = 3'd1,
    WR_THRESH = 3'd2,
    RUN       = 3'd3,
    STOP      = 3'd4
  } ebc_state_t;

  // Default register offsets inside the enable_generator AXI-lite map.
  localparam logic [31:0] DEF_PERIOD_OFFSET    = 32'h4;
  localparam logic [31:0] DEF_THRESHOLD_OFFSET = 32'h8;

  // AXI write response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_simple_write_master.sv
// Single-beat AXI-lite write master. A go pulse launches one write of data to
// addr; done strobes on the B handshake with the slave's response on resp.
//
// Handshake rule: a channel transfers on a rising clock edge where valid and
// ready are both high. Once raised, a valid (and its payload) is held until
// that transfer happens; AW and W are raised together and each drops on its
// own handshake. go must only be asserted when no write is outstanding.
module axil_simple_write_master
  import enable_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        done,
  output logic [1:0]  resp,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp
);

  assign wstrb = 4'hF;
  assign done  = bvalid && bready;
  assign resp  = bresp;

  // Launch on go, retire each channel on its own handshake, release bready on B.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      awaddr  <= 32'h0;
      wdata   <= 32'h0;
    end else if (go) begin
      awvalid <= 1'b1;
      wvalid  <= 1'b1;
      bready  <= 1'b1;
      awaddr  <= addr;
      wdata   <= data;
    end else begin
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready)   wvalid  <= 1'b0;
      if (done)               bready  <= 1'b0;
    end
  end

endmodule

// File: rtl/enable_burst_controller.sv
// Programs an enable_generator over AXI-lite, then gates it on for a burst of
// cfg_burst_len pulses (0 = until abort) and reports completion with done.
module enable_burst_controller
  import enable_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h0,
  parameter logic [31:0] PERIOD_OFFSET    = DEF_PERIOD_OFFSET,
  parameter logic [31:0] THRESHOLD_OFFSET = DEF_THRESHOLD_OFFSET,
  parameter int          COUNT_W          = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        cfg_period,
  input  logic [31:0]        cfg_threshold,
  input  logic [COUNT_W-1:0] cfg_burst_len,
  output logic               gen_enable,
  input  logic               gen_pulse,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] pulse_count,
  output logic [2:0]         fsm_state,
  output logic               axil_awvalid,
  input  logic               axil_awready,
  output logic [31:0]        axil_awaddr,
  output logic               axil_wvalid,
  input  logic               axil_wready,
  output logic [31:0]        axil_wdata,
  output logic [3:0]         axil_wstrb,
  input  logic               axil_bvalid,
  output logic               axil_bready,
  input  logic [1:0]         axil_bresp,
  output logic               axil_arvalid,
  output logic [31:0]        axil_araddr,
  output logic               axil_rready
);

  ebc_state_t         state;
  logic [31:0]        thresh_q;
  logic [COUNT_W-1:0] len_q;
  logic               abort_seen;
  logic               pulse_q;
  logic               edge_q;
  logic               accept;
  logic               thresh_go;
  logic               wr_go;
  logic               wr_done;
  logic [1:0]         wr_resp;
  logic [31:0]        wr_addr;
  logic [31:0]        wr_data;
  logic               hit_len;
  logic               count_en;

  // Read channels are never used.
  assign axil_arvalid = 1'b0;
  assign axil_araddr  = 32'h0;
  assign axil_rready  = 1'b1;

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // abort beats start in IDLE.
  assign accept    = (state == IDLE) && start && !abort;
  // Threshold write launches on the same edge the period write's B completes,
  // unless an abort arrived during the period write.
  assign thresh_go = (state == WR_PERIOD) && wr_done && (wr_resp == RESP_OKAY)
                     && !abort && !abort_seen;
  assign wr_go     = accept || thresh_go;
  // The period write launches straight from the start cycle, so it takes the
  // live cfg_period; the master holds its own copy for the transaction.
  assign wr_addr   = (state == IDLE) ? (BASE_ADDR + PERIOD_OFFSET)
                                     : (BASE_ADDR + THRESHOLD_OFFSET);
  assign wr_data   = (state == IDLE) ? cfg_period : thresh_q;

  // Counting continues in STOP so a pulse coinciding with abort is not lost.
  assign count_en  = edge_q && ((state == RUN) || (state == STOP))
                     && (pulse_count != '1);
  assign hit_len   = (state == RUN) && edge_q && (len_q != '0)
                     && (pulse_count == len_q - COUNT_W'(1));

  axil_simple_write_master u_wr (
    .clock   (clock),
    .reset   (reset),
    .go      (wr_go),
    .addr    (wr_addr),
    .data    (wr_data),
    .done    (wr_done),
    .resp    (wr_resp),
    .awvalid (axil_awvalid),
    .awready (axil_awready),
    .awaddr  (axil_awaddr),
    .wvalid  (axil_wvalid),
    .wready  (axil_wready),
    .wdata   (axil_wdata),
    .wstrb   (axil_wstrb),
    .bvalid  (axil_bvalid),
    .bready  (axil_bready),
    .bresp   (axil_bresp)
  );

  // Pulse edge detect (one register stage) and saturating pulse counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pulse_q     <= 1'b0;
      edge_q      <= 1'b0;
      pulse_count <= '0;
    end else begin
      pulse_q <= gen_pulse;
      edge_q  <= gen_pulse && !pulse_q;
      if (accept)        pulse_count <= '0;
      else if (count_en) pulse_count <= pulse_count + COUNT_W'(1);
    end
  end

  // Sequencer: program period, program threshold, run burst, stop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gen_enable <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      abort_seen <= 1'b0;
      thresh_q   <= 32'h0;
      len_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            thresh_q   <= cfg_threshold;
            len_q      <= cfg_burst_len;
            error      <= 1'b0;
            abort_seen <= 1'b0;
            state      <= WR_PERIOD;
          end
        end
        WR_PERIOD: begin
          if (abort) abort_seen <= 1'b1;
          if (wr_done) begin
            if (wr_resp != RESP_OKAY) begin
              error <= 1'b1;
              state <= STOP;
            end else if (abort || abort_seen) begin
              state <= STOP;
            end else begin
              state <= WR_THRESH;
            end
          end
        end
        WR_THRESH: begin
          if (abort) abort_seen <= 1'b1;
          if (wr_done) begin
            if (wr_resp != RESP_OKAY) begin
              error <= 1'b1;
              state <= STOP;
            end else if (abort || abort_seen) begin
              state <= STOP;
            end else begin
              gen_enable <= 1'b1;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          if (abort || hit_len) state <= STOP;
        end
        STOP: begin
          gen_enable <= 1'b0;
          done       <= 1'b1;
          abort_seen <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enable_burst_controller.sv
// Bench for enable_burst_controller: behavioural AXI-lite slave with
// programmable ready skew and error injection, plus an enable_generator model
// (period counter, one-cycle pulse when the counter equals the threshold).
module tb_enable_burst_controller;
  import enable_ctrl_pkg::*;

  localparam int COUNT_W = 16;
  localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

  logic               clock;
  logic               reset;
  logic               start;
  logic               abort;
  logic [31:0]        cfg_period;
  logic [31:0]        cfg_threshold;
  logic [COUNT_W-1:0] cfg_burst_len;
  logic               gen_enable;
  logic               gen_pulse;
  logic               busy;
  logic               done;
  logic               error;
  logic [COUNT_W-1:0] pulse_count;
  logic [2:0]         fsm_state;
  logic               awvalid, awready, wvalid, wready, bvalid, bready;
  logic               arvalid, rready;
  logic [31:0]        awaddr, wdata, araddr;
  logic [3:0]         wstrb;
  logic [1:0]         bresp;

  int errors;
  int checks;
  int cyc = 0;

  // slave configuration (driven only by the stimulus process)
  int          aw_delay;
  int          w_delay;
  logic [31:0] err_addr;

  // slave / generator state
  logic        aw_got = 1'b0, w_got = 1'b0;
  int          aw_cnt = 0, w_cnt = 0;
  logic [31:0] aw_addr_q, w_data_q;
  logic        aw_hs, w_hs;
  logic [31:0] cur_addr, cur_data;
  logic [31:0] gen_period, gen_thresh, gen_cnt;
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];

  // monitors (never cleared; tests work on differences)
  int   pulse_cyc[$];
  int   done_cyc[$];
  int   en_fall_cyc[$];
  int   en_rise_cnt = 0, aw_hi = 0, w_hi = 0, viol = 0;
  logic prev_en = 1'b0, prev_awv = 1'b0, prev_awr = 1'b0, prev_wv = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_awaddr = 32'h0, prev_wdata = 32'h0;

  enable_burst_controller dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .cfg_period    (cfg_period),
    .cfg_threshold (cfg_threshold),
    .cfg_burst_len (cfg_burst_len),
    .gen_enable    (gen_enable),
    .gen_pulse     (gen_pulse),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .pulse_count   (pulse_count),
    .fsm_state     (fsm_state),
    .axil_awvalid  (awvalid),
    .axil_awready  (awready),
    .axil_awaddr   (awaddr),
    .axil_wvalid   (wvalid),
    .axil_wready   (wready),
    .axil_wdata    (wdata),
    .axil_wstrb    (wstrb),
    .axil_bvalid   (bvalid),
    .axil_bready   (bready),
    .axil_bresp    (bresp),
    .axil_arvalid  (arvalid),
    .axil_araddr   (araddr),
    .axil_rready   (rready)
  );

  // clock / reset-independent cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // AXI-lite slave: ready after aw_delay / w_delay waiting cycles, B the cycle after both land
  assign awready  = !aw_got && (aw_cnt >= aw_delay);
  assign wready   = !w_got && (w_cnt >= w_delay);
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign cur_addr = aw_hs ? awaddr : aw_addr_q;
  assign cur_data = w_hs ? wdata : w_data_q;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
      bvalid <= 1'b0; bresp <= 2'b00; aw_addr_q <= 32'h0; w_data_q <= 32'h0;
      gen_period <= 32'h0; gen_thresh <= 32'h0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1; aw_addr_q <= awaddr; aw_cnt <= 0;
      end else if (awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin
        w_got <= 1'b1; w_data_q <= wdata; w_cnt <= 0;
      end else if (wvalid && !w_got) w_cnt <= w_cnt + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b1;
        wr_addr_log.push_back(cur_addr);
        wr_data_log.push_back(cur_data);
        if (cur_addr == err_addr) bresp <= RESP_SLVERR;
        else begin
          bresp <= RESP_OKAY;
          if (cur_addr == 32'h4)      gen_period <= cur_data;
          else if (cur_addr == 32'h8) gen_thresh <= cur_data;
        end
      end
    end
  end

  // enable_generator model
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      gen_cnt <= 32'h0; gen_pulse <= 1'b0;
    end else if (gen_enable) begin
      gen_pulse <= (gen_cnt == gen_thresh);
      gen_cnt   <= (gen_cnt >= gen_period - 32'h1) ? 32'h0 : gen_cnt + 32'h1;
    end else begin
      gen_cnt <= 32'h0; gen_pulse <= 1'b0;
    end
  end

  // monitors sampled on the falling edge
  always @(negedge clock) begin
    if (gen_pulse) pulse_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
    if (prev_en && !gen_enable) en_fall_cyc.push_back(cyc);
    if (!prev_en && gen_enable) en_rise_cnt <= en_rise_cnt + 1;
    if (awvalid) aw_hi <= aw_hi + 1;
    if (wvalid) w_hi <= w_hi + 1;
    if ((prev_awv && !prev_awr && (!awvalid || awaddr != prev_awaddr)) ||
        (prev_wv && !prev_wr && (!wvalid || wdata != prev_wdata)))
      viol <= viol + 1;
    prev_en <= gen_enable; prev_awv <= awvalid; prev_awr <= awready;
    prev_wv <= wvalid; prev_wr <= wready; prev_awaddr <= awaddr; prev_wdata <= wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] p, input logic [31:0] t, input logic [15:0] len);
    @(negedge clock);
    cfg_period = p; cfg_threshold = t; cfg_burst_len = len; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clock); #1;
      if (done) seen = 1'b1;
      n++;
    end
    check(tag, {31'h0, seen}, 32'h1);
  endtask

  task automatic wait_pulses(input string tag, input int base, input int target, input int budget);
    int n = 0;
    while ((pulse_cyc.size() - base) < target && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    check(tag, pulse_cyc.size() - base, target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gen_enable"}, {31'h0, gen_enable}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_error"}, {31'h0, error}, 32'h0);
    check({tag, "_pulse_count"}, {16'h0, pulse_count}, 32'h0);
    check({tag, "_awvalid"}, {31'h0, awvalid}, 32'h0);
    check({tag, "_wvalid"}, {31'h0, wvalid}, 32'h0);
    check({tag, "_bready"}, {31'h0, bready}, 32'h0);
    check({tag, "_state"}, {29'h0, fsm_state}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pb, wb, db, fb, rb, ab, whb, vb, bad, last, a_cyc;
    errors = 0; checks = 0;
    start = 1'b0; abort = 1'b0;
    cfg_period = 32'h0; cfg_threshold = 32'h0; cfg_burst_len = '0;
    aw_delay = 0; w_delay = 0; err_addr = NO_ERR;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1 check_reset_values("rst");
    check("rst_arvalid", {31'h0, arvalid}, 32'h0);
    check("rst_rready", {31'h0, rready}, 32'h1);
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);

    // 1: period 0x10, threshold 4, burst 8
    pb = pulse_cyc.size(); wb = wr_addr_log.size(); db = done_cyc.size(); fb = en_fall_cyc.size();
    do_start(32'h10, 32'h4, 16'd8);
    #1;
    check("t1_awvalid_1cyc", {31'h0, awvalid}, 32'h1);
    check("t1_wvalid_1cyc", {31'h0, wvalid}, 32'h1);
    check("t1_awaddr", awaddr, 32'h4);
    check("t1_wstrb", {28'h0, wstrb}, 32'hF);
    check("t1_busy", {31'h0, busy}, 32'h1);
    wait_done("t1_done_seen", 400);
    check("t1_pulses", pulse_cyc.size() - pb, 8);
    bad = 0;
    for (int i = pb + 1; i < pulse_cyc.size(); i++)
      if (pulse_cyc[i] - pulse_cyc[i-1] != 16) bad++;
    check("t1_spacing_bad", bad, 0);
    last = (pulse_cyc.size() > pb) ? pulse_cyc[pulse_cyc.size()-1] : -100;
    check("t1_done_lat", ((done_cyc.size() > db) ? done_cyc[db] : -1) - last, 3);
    check("t1_en_fall_lat", ((en_fall_cyc.size() > fb) ? en_fall_cyc[fb] : -1) - last, 3);
    check("t1_count", {16'h0, pulse_count}, 32'd8);
    check("t1_wr_n", wr_addr_log.size() - wb, 2);
    if (wr_addr_log.size() - wb >= 2) begin
      check("t1_wr0_addr", wr_addr_log[wb], 32'h4);
      check("t1_wr0_data", wr_data_log[wb], 32'h10);
      check("t1_wr1_addr", wr_addr_log[wb+1], 32'h8);
      check("t1_wr1_data", wr_data_log[wb+1], 32'h4);
    end
    check("t1_gen_period", gen_period, 32'h10);
    check("t1_gen_thresh", gen_thresh, 32'h4);
    repeat (5) @(negedge clock); #1;
    check("t1_done_once", done_cyc.size() - db, 1);
    check("t1_idle", {31'h0, busy}, 32'h0);
    check("t1_error", {31'h0, error}, 32'h0);

    // 2: continuous, period 0x20, abort together with the 5th pulse
    pb = pulse_cyc.size(); db = done_cyc.size();
    do_start(32'h20, 32'h4, 16'd0);
    wait_pulses("t2_five_pulses", pb, 5, 400);
    abort = 1'b1; a_cyc = cyc;
    @(negedge clock); abort = 1'b0;
    wait_done("t2_done_seen", 10);
    check("t2_spacing", ((pulse_cyc.size() > pb + 1) ? pulse_cyc[pb+1] - pulse_cyc[pb] : 0), 32);
    check("t2_done_within_2", {31'h0, (((done_cyc.size() > db) ? done_cyc[db] : 9999) - a_cyc) <= 2}, 32'h1);
    repeat (100) @(negedge clock); #1;
    check("t2_no_more_pulses", pulse_cyc.size() - pb, 5);
    check("t2_count", {16'h0, pulse_count}, 32'd5);
    check("t2_gen_enable", {31'h0, gen_enable}, 32'h0);

    // 3: AW ready after 3 waits, W after 1
    aw_delay = 3; w_delay = 1;
    ab = aw_hi; whb = w_hi; vb = viol;
    do_start(32'h18, 32'h2, 16'd3);
    wait_done("t3_done_seen", 400);
    check("t3_valid_drop_viol", viol - vb, 0);
    check("t3_aw_valid_cycles", aw_hi - ab, 8);
    check("t3_w_valid_cycles", w_hi - whb, 4);
    check("t3_gen_period", gen_period, 32'h18);
    check("t3_gen_thresh", gen_thresh, 32'h2);
    check("t3_count", {16'h0, pulse_count}, 32'd3);
    aw_delay = 0; w_delay = 0;

    // 4: SLVERR on the period write, then a clean start clears error
    err_addr = 32'h4;
    rb = en_rise_cnt; wb = wr_addr_log.size(); db = done_cyc.size();
    do_start(32'h10, 32'h4, 16'd2);
    wait_done("t4_done_seen", 50);
    check("t4_error", {31'h0, error}, 32'h1);
    repeat (3) @(negedge clock); #1;
    check("t4_no_enable", en_rise_cnt - rb, 0);
    check("t4_one_write", wr_addr_log.size() - wb, 1);
    check("t4_done_once", done_cyc.size() - db, 1);
    check("t4_error_sticky", {31'h0, error}, 32'h1);
    err_addr = NO_ERR;
    do_start(32'h10, 32'h3, 16'd2);
    #1 check("t4_error_cleared", {31'h0, error}, 32'h0);
    wait_done("t4b_done_seen", 200);
    check("t4b_count", {16'h0, pulse_count}, 32'd2);

    // 5: start during RUN is ignored
    pb = pulse_cyc.size(); wb = wr_addr_log.size();
    do_start(32'h10, 32'h4, 16'd4);
    wait_pulses("t5_first_pulse", pb, 1, 200);
    cfg_period = 32'h63; cfg_threshold = 32'h1; cfg_burst_len = 16'd1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_done("t5_done_seen", 200);
    check("t5_count", {16'h0, pulse_count}, 32'd4);
    check("t5_pulses", pulse_cyc.size() - pb, 4);
    check("t5_writes", wr_addr_log.size() - wb, 2);
    check("t5_gen_period", gen_period, 32'h10);

    // 6: start and abort together in IDLE
    @(negedge clock); start = 1'b1; abort = 1'b1;
    @(negedge clock); start = 1'b0; abort = 1'b0;
    #1;
    check("t6_busy", {31'h0, busy}, 32'h0);
    check("t6_awvalid", {31'h0, awvalid}, 32'h0);

    // 7: reset asserted during the threshold write, then a fresh burst
    do_start(32'h10, 32'h4, 16'd4);
    begin
      int n = 0;
      while (!(awvalid && awaddr == 32'h8) && n < 20) begin @(negedge clock); #1; n++; end
      check("t7_reached_thresh_write", {31'h0, awvalid && awaddr == 32'h8}, 32'h1);
    end
    reset = 1'b0;
    #1 check_reset_values("t7_rst");
    @(negedge clock); reset = 1'b1;
    pb = pulse_cyc.size();
    do_start(32'h14, 32'h3, 16'd2);
    wait_done("t7_done_seen", 200);
    check("t7_count", {16'h0, pulse_count}, 32'd2);
    check("t7_gen_period", gen_period, 32'h14);
    check("t7_gen_thresh", gen_thresh, 32'h3);
    check("t7_pulses", pulse_cyc.size() - pb, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enable_burst_controller.md
# enable_burst_controller

Sequencer that configures and gates one `enable_generator` instance. On a start command it programs the generator's period and threshold registers over its AXI-lite slave port. It then asserts the generator enable and counts the enable pulses it produces. After a programmed burst length it shuts the generator off. It sits between the control core and the generator; the generator's AXI-lite port is owned exclusively by this block.

## Interface
- `BASE_ADDR`, 0: AXI-lite base address of the driven generator.
- `PERIOD_OFFSET`, 'h4: period register offset.
- `THRESHOLD_OFFSET`, 'h8: threshold (phase) register offset.
- `COUNT_W`, 16: width of burst length and pulse counter.
- `clock`  in  1  single system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  level; forces an orderly stop.
- `cfg_period`  in  32  period value, latched on accepted start.
- `cfg_threshold`  in  32  threshold value, latched on accepted start.
- `cfg_burst_len`  in  COUNT_W  pulses per burst; 0 means continuous until abort.
- `gen_enable`  out  1  drives the generator's `gen_enable_in`.
- `gen_pulse`  in  1  the generator's `enable_out`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle strobe on burst completion or abort completion.
- `error`  out  1  sticky; set on a non-OKAY BRESP, cleared by the next accepted start.
- `pulse_count`  out  COUNT_W  pulses seen in the current or last burst.
- `axil`  master  axi_lite  write-only master; AR/R channels are tied idle (`arvalid`=0, `rready`=1).

## Operation
- FSM states: IDLE, WR_PERIOD, WR_THRESH, RUN, STOP.
- IDLE + `start`:
  - latch cfg_*;
  - clear `pulse_count` and `error`;
  - go to WR_PERIOD.
- WR_PERIOD / WR_THRESH perform one AXI-lite write each:
  - `awaddr` = BASE_ADDR + offset, `wstrb` = 'hF;
  - AW and W valid are raised together, and each drops independently on its own ready;
  - `bready` is held high;
  - on the B handshake, go to the next state.
  - BRESP ≠ OKAY: set `error`, skip to STOP.
- WR_THRESH done → RUN, with `gen_enable` = 1.
- RUN:
  - rising edge of `gen_pulse` (registered previous value, edge detected) increments `pulse_count`;
  - when the increment makes `pulse_count` == `cfg_burst_len` (non-zero), `gen_enable` drops the next cycle and the FSM goes to STOP.
- STOP: `gen_enable` = 0, `done` pulses for one cycle, return to IDLE.
- `abort`:
  - in a write state, the outstanding transaction completes (never drop valid mid-handshake), then STOP;
  - in RUN, go to STOP next cycle;
  - in IDLE, no effect.
- `start` outside IDLE is ignored.
- `pulse_count` saturates at its maximum in continuous mode.

## Timing
- Reset values:
  - FSM = IDLE;
  - `gen_enable`, `busy`, `done`, `error` = 0;
  - `pulse_count` = 0;
  - all AXI valids = 0, `bready` = 0.
- Reset during a transaction aborts it immediately; the generator is re-programmed on the next start.
- Start to AW/W valid: 1 cycle.
- Register write with a zero-wait slave: 3 cycles (valid, B, next).
- Pulse edge to `pulse_count` update: 2 cycles (edge register + counter).
- Last pulse to `gen_enable` low: 3 cycles.
- Last pulse to `done`: 3 cycles.
- A pulse arriving in the same cycle as `abort` in RUN is counted.
- `start` and `abort` together in IDLE: abort wins, start is ignored.

## Structure
- Package `enable_ctrl_pkg` holds:
  - the state enum `ebc_state_t`;
  - the default register offsets;
  - the `RESP_OKAY` constant.
- Sub-module `axil_simple_write_master` issues one write (addr, data, go → done, resp). It is instantiated once and reused by both write states.

## Test plan
- Bench pairs this block with a real `enable_generator` on a shared AXI-lite interface.
- Period 'h10, threshold 4, burst 8, start:
  - two writes land at 'h4 ('h10) and 'h8 (4);
  - exactly 8 pulses, 16 cycles apart;
  - `gen_enable` low and `done` at last pulse + 3;
  - `pulse_count` = 8.
- Burst 0, period 'h20: pulses continue 32 cycles apart; `abort` after 5 pulses → `done` within 2 cycles, no further pulses, `pulse_count` = 5.
- Slave with 3-cycle AWREADY and WREADY skew: valids are held until each handshake completes, and data is correct in the generator.
- Slave returns SLVERR on the period write: `error` = 1, `gen_enable` never rises, `done` pulses; the next start clears `error`.
- `start` pulsed during RUN, and `reset` asserted mid WR_THRESH:
  - the `start` is ignored;
  - after the reset, all outputs are at reset values and a fresh start completes a normal burst.
